// File: rtl/cache_line_fill.sv
// ---------------------------------------------------------------------------
// cache_line_fill
//   Refill engine between a direct-mapped cache and main memory. A miss
//   fetches the whole line one word per beat, starting at the missing word
//   and wrapping around the line. The missing word is forwarded as soon as it
//   arrives. The assembled line is then presented to the cache, together
//   with its tag and index, until the cache acknowledges the write.
//   A saturating counter records every miss that is accepted.
//
// Ports
//   clk, rst          clock (rising edge), async active-low reset
//   miss_req/addr     miss request and word address (sampled in IDLE only)
//   busy              engine not idle
//   mem_rd/addr       memory read request and beat address (held until ack)
//   mem_ack/data      memory returns a word
//   word_valid/data   one-cycle pulse carrying the critical word
//   line_valid/data   full line held until line_ack
//   line_tag/index    location of the filled line
//   line_ack          cache has written the line
//   miss_count        saturating count of accepted misses
// ---------------------------------------------------------------------------
module cache_line_fill #(
  parameter int WORD_SIZE   = 32,
  parameter int WORD_COUNT  = 4,
  parameter int ADDR_WIDTH  = 15,
  parameter int COUNT_WIDTH = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            miss_req,
  input  logic [ADDR_WIDTH-1:0]           miss_addr,
  output logic                            busy,
  output logic                            mem_rd,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic                            mem_ack,
  input  logic [WORD_SIZE-1:0]            mem_data,
  output logic                            word_valid,
  output logic [WORD_SIZE-1:0]            word_data,
  output logic                            line_valid,
  output logic [WORD_COUNT*WORD_SIZE-1:0] line_data,
  output logic [ADDR_WIDTH-13:0]          line_tag,
  output logic [9:0]                      line_index,
  input  logic                            line_ack,
  output logic [COUNT_WIDTH-1:0]          miss_count
);

  localparam int OFF_W = $clog2(WORD_COUNT);
  localparam int IDX_W = 10;
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [OFF_W-1:0]       BEAT_LAST = OFF_W'(WORD_COUNT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [1:0]             state_q, state_d;
  logic [OFF_W-1:0]       beat_q, beat_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [OFF_W-1:0]       off_q, off_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   wvld_q, wvld_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic                   lvld_q, lvld_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WORD_COUNT-1:0][WORD_SIZE-1:0] line_q;

  // Slot being filled this beat: the critical word offset rotated by the
  // beat number, wrapping naturally in OFF_W bits.
  logic [OFF_W-1:0] wr_slot;
  logic [OFF_W-1:0] nxt_slot;
  logic             beat_ack;

  assign wr_slot  = off_q + beat_q;
  assign nxt_slot = wr_slot + OFF_W'(1);
  assign beat_ack = (state_q == FETCH) && mem_ack;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    off_d      = off_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    wvld_d     = 1'b0;
    wdata_d    = wdata_q;
    lvld_d     = lvld_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (miss_req) begin
          state_d    = FETCH;
          tag_d      = miss_addr[ADDR_WIDTH-1 -: TAG_W];
          idx_d      = miss_addr[OFF_W +: IDX_W];
          off_d      = miss_addr[OFF_W-1:0];
          beat_d     = '0;
          mem_rd_d   = 1'b1;
          // First beat fetches the missing word itself.
          mem_addr_d = miss_addr;
          cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
        end
      end
      FETCH: begin
        if (mem_ack) begin
          if (beat_q == '0) begin
            wdata_d = mem_data;
            wvld_d  = 1'b1;
          end
          if (beat_q == BEAT_LAST) begin
            state_d  = DONE;
            mem_rd_d = 1'b0;
            lvld_d   = 1'b1;
          end else begin
            beat_d     = beat_q + OFF_W'(1);
            mem_addr_d = {tag_q, idx_q, nxt_slot};
          end
        end
      end
      DONE: begin
        if (line_ack) begin
          state_d = IDLE;
          lvld_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      off_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      wvld_q     <= 1'b0;
      wdata_q    <= '0;
      lvld_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      off_q      <= off_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      wvld_q     <= wvld_d;
      wdata_q    <= wdata_d;
      lvld_q     <= lvld_d;
      cnt_q      <= cnt_d;
    end
  end

  // Line buffer: one register per word slot. Slots untouched by the current
  // fill keep whatever the previous fill left; only a complete line is ever
  // flagged valid, so stale words are never exposed as good data.
  for (genvar g = 0; g < WORD_COUNT; g++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  line_q[g] <= '0;
      else if (beat_ack && wr_slot == OFF_W'(g)) line_q[g] <= mem_data;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign word_valid = wvld_q;
  assign word_data  = wdata_q;
  assign line_valid = lvld_q;
  assign line_data  = line_q;
  assign line_tag   = tag_q;
  assign line_index = idx_q;
  assign miss_count = cnt_q;

endmodule
